// File: rtl/game_pkg.sv
// Shared types and default sizes for the answer-check path.
package game_pkg;

   localparam int KEY_W           = 4;
   localparam int SEQ_MAX         = 8;
   localparam int STEP_W          = 3;
   localparam int TIMEOUT_CYC_DEF = 50_000_000;

   typedef logic [KEY_W-1:0] key_t;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_KEY     = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Button input path: 2-flop synchronizer, a third flop for edge detection,
// a registered press event with the captured key vector, and an all-released flag.
module key_sync_edge #(
   parameter int KEY_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [KEY_W-1:0] key,
   output logic             press,
   output logic [KEY_W-1:0] pressed_code,
   output logic             all_released
);

   logic [KEY_W-1:0] sync1;
   logic [KEY_W-1:0] sync2;
   logic [KEY_W-1:0] sync3;
   logic             rise;

   // A press is the first cycle any synchronized key is high after all were low.
   assign rise         = (|sync2) & ~(|sync3);
   assign all_released = ~(|sync2);

   // Synchronizer chain plus registered press event and captured code.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1        <= '0;
         sync2        <= '0;
         sync3        <= '0;
         press        <= 1'b0;
         pressed_code <= '0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         sync3 <= sync2;
         press <= rise;
         if (rise) pressed_code <= sync2;
      end
   end

endmodule

// File: rtl/answer_check.sv
// Checks player button presses against a loaded target key sequence.
// Optional macro ANSWER_CHECK_TIMEOUT_EN adds a WAIT_KEY inactivity timeout.
//
// state        | meaning
// IDLE         | no attempt running, waiting for arm
// WAIT_KEY     | attempt running, waiting for the next press event
// WAIT_RELEASE | press handled, waiting for all keys up (then WAIT_KEY or IDLE)
module answer_check
   import game_pkg::*;
#(
   parameter int KEY_W   = game_pkg::KEY_W,
   parameter int SEQ_MAX = game_pkg::SEQ_MAX,
   parameter int STEP_W  = game_pkg::STEP_W
`ifdef ANSWER_CHECK_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = game_pkg::TIMEOUT_CYC_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pat_we,
   input  logic [STEP_W-1:0] pat_addr,
   input  logic [KEY_W-1:0]  pat_data,
   input  logic [STEP_W:0]   seq_len,
   input  logic              arm,
   input  logic [KEY_W-1:0]  key,
   output logic              true_pulse,
   output logic              wrong_pulse,
   output logic [STEP_W-1:0] step,
   output logic              busy
);

   localparam logic [STEP_W:0]   MAX_LEN  = (STEP_W+1)'(SEQ_MAX);
   localparam logic [STEP_W:0]   LEN_ONE  = (STEP_W+1)'(1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [KEY_W-1:0]  CODE_ONE = KEY_W'(1);

   state_t            state;
   logic [STEP_W:0]   len;
   logic              finished;
   logic [KEY_W-1:0]  pattern [SEQ_MAX];

   logic              press;
   logic [KEY_W-1:0]  pressed_code;
   logic              all_released;

   logic              len_ok;
   logic              code_ok;
   logic              code_match;
   logic              last_step;

   key_sync_edge #(.KEY_W(KEY_W)) u_key_sync_edge (
      .clk          (clk),
      .reset        (reset),
      .key          (key),
      .press        (press),
      .pressed_code (pressed_code),
      .all_released (all_released)
   );

   assign len_ok     = (seq_len != '0) && (seq_len <= MAX_LEN);
   assign code_ok    = (pressed_code != '0) &&
                       ((pressed_code & (pressed_code - CODE_ONE)) == '0);
   assign code_match = code_ok && (pressed_code == pattern[step]);
   assign last_step  = ({1'b0, step} == (len - LEN_ONE));

   // Pattern register file; a compare in the same cycle as a write sees the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SEQ_MAX; i++) pattern[i] <= '0;
      end else if (pat_we) begin
         pattern[pat_addr] <= pat_data;
      end
   end

`ifdef ANSWER_CHECK_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
   logic [31:0] tmo_cnt;

   // Inactivity counter: runs only in WAIT_KEY, restarted by arm and every press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (arm || press || (state != WAIT_KEY)) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end
`endif

   // Attempt FSM with registered pulses, step and busy; arm overrides everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         step        <= '0;
         len         <= '0;
         finished    <= 1'b0;
         true_pulse  <= 1'b0;
         wrong_pulse <= 1'b0;
         busy        <= 1'b0;
      end else begin
         true_pulse  <= 1'b0;
         wrong_pulse <= 1'b0;
         if (arm) begin
            step <= '0;
            if (len_ok) begin
               len      <= seq_len;
               finished <= 1'b0;
               state    <= WAIT_KEY;
               busy     <= 1'b1;
            end else begin
               wrong_pulse <= 1'b1;
               state       <= IDLE;
               busy        <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  step <= '0;
                  busy <= 1'b0;
               end
               WAIT_KEY: begin
                  if (press) begin
                     state <= WAIT_RELEASE;
                     if (!code_match) begin
                        wrong_pulse <= 1'b1;
                        step        <= '0;
                        finished    <= 1'b1;
                     end else if (last_step) begin
                        true_pulse <= 1'b1;
                        step       <= '0;
                        finished   <= 1'b1;
                     end else begin
                        step     <= step + STEP_ONE;
                        finished <= 1'b0;
                     end
                  end
`ifdef ANSWER_CHECK_TIMEOUT_EN
                  else if (tmo_cnt == TMO_LAST) begin
                     wrong_pulse <= 1'b1;
                     step        <= '0;
                     state       <= IDLE;
                     busy        <= 1'b0;
                  end
`endif
               end
               WAIT_RELEASE: begin
                  if (all_released) begin
                     if (finished) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= WAIT_KEY;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  step  <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/answer_check.md
Name: answer_check

Overview:
- Upstream neighbour of the stage-clear counter. Checks the player's button presses against a per-stage target key sequence.
- Emits a one-cycle true_pulse on a fully correct sequence. This pulse is the trueStack input of the stage-clear block.
- Emits a one-cycle wrong_pulse on any error.
- Holds the target pattern in a small register file loaded by the stage controller.

Parameters:
- KEY_W, 4, number of player buttons; key codes are one-hot KEY_W bits.
- SEQ_MAX, 8, maximum sequence length (power of two).
- STEP_W, 3, log2(SEQ_MAX); width of step index and pattern address.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pat_we  in  1  write strobe for the pattern register file.
- pat_addr  in  STEP_W  pattern slot to write.
- pat_data  in  KEY_W  one-hot key code for that slot.
- seq_len  in  STEP_W+1  active sequence length, 1..SEQ_MAX; sampled on arm.
- arm  in  1  one-cycle pulse: start checking a new attempt from step 0.
- key  in  KEY_W  raw asynchronous buttons, active-high.
- true_pulse  out  1  one cycle high when the whole sequence has been entered correctly.
- wrong_pulse  out  1  one cycle high on a wrong key, a multi-key press or an illegal length.
- step  out  STEP_W  index of the next expected key.
- busy  out  1  high while an attempt is in progress.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0. Pattern file cleared to 0. Synchronizers and latched length cleared. FSM in IDLE.
- Key input path:
  - Each key bit passes through a 2-flop synchronizer and a third flop for edge detection.
  - A press event is the registered rising edge of the OR of the synchronized key bits.
  - pressed_code is the synchronized vector captured at that edge.
  - Latency from raw key edge to press event: 3 clk.
- FSM states: IDLE, WAIT_KEY, WAIT_RELEASE.
  - IDLE: busy=0, step=0.
    - On arm with 1 <= seq_len <= SEQ_MAX: latch seq_len, go to WAIT_KEY, busy=1 next cycle.
    - On arm with seq_len=0 or seq_len>SEQ_MAX: pulse wrong_pulse, stay in IDLE.
  - WAIT_KEY: on a press event, compare pressed_code to pattern[step].
    - Not exactly one bit set, or mismatch: wrong_pulse=1 for one cycle, step<=0, go to WAIT_RELEASE, then IDLE.
    - Match and step == len-1: true_pulse=1 for one cycle, step<=0, go to WAIT_RELEASE, then IDLE.
    - Match otherwise: step<=step+1, go to WAIT_RELEASE.
  - WAIT_RELEASE: when all synchronized keys are 0, return to WAIT_KEY (attempt continuing) or IDLE (attempt finished). New presses are ignored until release.
- Pulses are registered and asserted the cycle after the decisive press event. true_pulse and wrong_pulse are never high together.
- Simultaneous events and priorities:
  - arm while busy: restarts the attempt (step<=0, re-latch len). arm has priority over a press event in the same cycle.
  - pat_we during an attempt: the write takes effect next cycle. A compare in the same cycle uses the old value.
  - pat_we to pat_addr >= len: stored; ignored by the current attempt.
- Asynchronous reset mid-attempt aborts immediately. No pulse is generated.

Optional Feature:
- Macro: ANSWER_CHECK_TIMEOUT_EN.
- With the macro:
  - Adds parameter TIMEOUT_CYC (default 50_000_000) and a counter that restarts on arm and on every press event.
  - If the counter reaches TIMEOUT_CYC in WAIT_KEY: wrong_pulse for one cycle, step<=0, go to IDLE.
  - The counter is held at 0 in IDLE and WAIT_RELEASE.
- Without the macro: no counter; WAIT_KEY waits indefinitely.

Decomposition:
- Shared package game_pkg holds:
  - the FSM state enum;
  - KEY_W, SEQ_MAX and STEP_W defaults;
  - a key-code typedef;
  - a TIMEOUT_CYC default.
- Sub-module key_sync_edge covers the synchronizer, the edge detector and the all-released flag. Parameter: KEY_W.

Test Plan:
- Load pattern 0001,0010,0100,1000; len=4; arm; press the 4 keys in order with release between each -> true_pulse once, 1 cycle, 4 clk after the 4th raw edge; step back at 0; busy=0.
- Same pattern; press 0001 then 0100 -> wrong_pulse on the 2nd press; step=0; busy=0 after release.
- Press 0011 (two keys) at step 0 -> wrong_pulse; no step advance.
- arm with seq_len=0 -> wrong_pulse in the next cycle; busy stays 0.
- Drop reset low while step=2 -> step=0, busy=0 and both pulses 0 immediately, without waiting for a clock edge. After release and arm, the sequence succeeds from step 0.
- With ANSWER_CHECK_TIMEOUT_EN and TIMEOUT_CYC=20: arm, no key for 20 clk -> wrong_pulse, IDLE. A key press at cycle 19 resets the counter with no pulse.
